// File: rtl/mmm_from_mont.sv
// Bit-serial radix-2 Montgomery reduction: o_res = T * 2^-K mod N, used to bring
// operands back out of the Montgomery domain. One request in flight at a time.
module mmm_from_mont #(
  parameter int WIDTH = 260,
  parameter int K     = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_t,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_valid,
  output logic             o_err
);

  localparam int ACC_W = WIDTH + 2;
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CORR, S_DONE} state_t;

  // One halving step mod N: make acc even by adding N when needed, then shift.
  function automatic logic [ACC_W-1:0] redc_step(input logic [ACC_W-1:0] acc,
                                                 input logic [WIDTH-1:0] n);
    return (acc[0] ? acc + {2'b00, n} : acc) >> 1;
  endfunction

  // acc < 2N after K steps, so one conditional subtraction lands in [0, N).
  function automatic logic [WIDTH-1:0] final_sub(input logic [ACC_W-1:0] acc,
                                                 input logic [WIDTH-1:0] n);
    return WIDTH'((acc >= {2'b00, n}) ? acc - {2'b00, n} : acc);
  endfunction

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic             oerr_q, oerr_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;
    valid_d = 1'b0;
    oerr_d  = oerr_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          acc_d   = {2'b00, i_t};
          n_d     = i_n;
          cnt_d   = '0;
          err_d   = ~i_n[0];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = redc_step(acc_q, n_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_CORR;
      end
      S_CORR: begin
        res_d   = final_sub(acc_q, n_q);
        valid_d = 1'b1;
        oerr_d  = err_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      oerr_q  <= oerr_d;
    end
  end

  // Modulus is pure data, captured only on acceptance.
  always_ff @(posedge i_clk) begin
    n_q <= n_d;
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_res   = res_q;
  assign o_valid = valid_q;
  assign o_err   = oerr_q;

endmodule

// File: tb/tb_mmm_from_mont.sv
// Bench for mmm_from_mont: directed checks on a 16-bit/K=8 instance and random
// vectors on the full 260-bit/K=256 instance against a modular-arithmetic model.
module tb_mmm_from_mont;

  localparam int SW = 16;
  localparam int SK = 8;
  localparam int LW = 260;
  localparam int LK = 256;
  localparam int NVEC = 250;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [SW-1:0] s_n, s_t, s_res;
  logic          s_valid, s_ready, s_ovalid, s_err;
  logic [LW-1:0] l_n, l_t, l_res;
  logic          l_valid, l_ready, l_ovalid, l_err;

  int checks = 0;
  int errors = 0;

  mmm_from_mont #(.WIDTH(SW), .K(SK)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_n(s_n), .i_t(s_t), .i_valid(s_valid),
    .o_ready(s_ready), .o_res(s_res), .o_valid(s_ovalid), .o_err(s_err)
  );

  mmm_from_mont #(.WIDTH(LW), .K(LK)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_n(l_n), .i_t(l_t), .i_valid(l_valid),
    .o_ready(l_ready), .o_res(l_res), .o_valid(l_ovalid), .o_err(l_err)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // (a*b) mod n with a double-width product
  function automatic logic [LW-1:0] mulmod(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                           input logic [LW-1:0] n);
    logic [2*LW-1:0] p;
    p = (2*LW)'(a) * (2*LW)'(b);
    p = p % (2*LW)'(n);
    return p[LW-1:0];
  endfunction

  // T * (2^-1)^k mod N, with 2^-1 = (N+1)/2 for odd N, by square-and-multiply
  function automatic logic [LW-1:0] from_mont_ref(input logic [LW-1:0] t, input logic [LW-1:0] n,
                                                  input int k);
    logic [LW-1:0] base, rinv;
    int e;
    base = (n + LW'(1)) >> 1;
    rinv = LW'(1) % n;
    e = k;
    while (e > 0) begin
      if (e[0]) rinv = mulmod(rinv, base, n);
      base = mulmod(base, base, n);
      e = e >> 1;
    end
    return mulmod(t % n, rinv, n);
  endfunction

  function automatic logic [LW-1:0] rand_wide();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[LW-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic start_small(input logic [SW-1:0] n, input logic [SW-1:0] t);
    int w;
    w = 0;
    while (!s_ready && w < 50) begin @(negedge clk); w++; end
    check("s_ready_before_req", LW'(s_ready), LW'(1));
    s_n = n; s_t = t; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("s_ready_low_after_accept", LW'(s_ready), LW'(0));
  endtask

  task automatic op_small(input string tag, input logic [SW-1:0] n, input logic [SW-1:0] t,
                          input logic [SW-1:0] exp_res, input logic exp_err, input logic chk_res);
    int cyc;
    start_small(n, t);
    cyc = 1;
    while (!s_ovalid && cyc < 40) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, LW'(cyc), LW'(SK + 2));
    if (chk_res) check({tag, "_res"}, LW'(s_res), LW'(exp_res));
    check({tag, "_err"}, LW'(s_err), LW'(exp_err));
    @(negedge clk);
    check({tag, "_valid_pulse_1cyc"}, LW'(s_ovalid), LW'(0));
    check({tag, "_ready_back"}, LW'(s_ready), LW'(1));
    if (chk_res) check({tag, "_res_held"}, LW'(s_res), LW'(exp_res));
  endtask

  task automatic op_large(input logic [LW-1:0] n, input logic [LW-1:0] t);
    int cyc, w;
    logic [LW-1:0] exp_res;
    exp_res = from_mont_ref(t, n, LK);
    w = 0;
    while (!l_ready && w < 50) begin @(negedge clk); w++; end
    l_n = n; l_t = t; l_valid = 1'b1;
    @(negedge clk);
    l_valid = 1'b0;
    cyc = 1;
    while (!l_ovalid && cyc < 400) begin @(negedge clk); cyc++; end
    check("l_latency", LW'(cyc), LW'(LK + 2));
    check("l_res", l_res, exp_res);
    check("l_err", LW'(l_err), LW'(0));
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [LW-1:0] n, t;
    rst = 1'b1;
    s_n = '0; s_t = '0; s_valid = 1'b0;
    l_n = '0; l_t = '0; l_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", LW'(s_ready), LW'(1));
    check("rst_s_valid", LW'(s_ovalid), LW'(0));
    check("rst_s_res", LW'(s_res), LW'(0));
    check("rst_s_err", LW'(s_err), LW'(0));
    check("rst_l_ready", LW'(l_ready), LW'(1));
    check("rst_l_valid", LW'(l_ovalid), LW'(0));
    check("rst_l_res", l_res, LW'(0));
    rst = 1'b0;
    @(negedge clk);

    op_small("basic", 16'd13, 16'd1, 16'd3, 1'b0, 1'b1);
    op_small("t_zero", 16'd13, 16'd0, 16'd0, 1'b0, 1'b1);
    op_small("t_rmod", 16'd13, 16'd9, 16'd1, 1'b0, 1'b1);
    op_small("t_2n_m1", 16'd13, 16'd25, 16'd10, 1'b0, 1'b1);
    op_small("even_n", 16'd12, 16'd5, 16'd0, 1'b1, 1'b0);
    op_small("after_even", 16'd13, 16'd1, 16'd3, 1'b0, 1'b1);

    // i_valid held high across a busy period
    s_n = 16'd13; s_t = 16'd1; s_valid = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 1) s_t = 16'd9;
      if (c == 11) check("busy_ready_idle", LW'(s_ready), LW'(1));
      if (c == 12) begin
        check("busy_second_accept", LW'(s_ready), LW'(0));
        s_valid = 1'b0;
      end
      if (s_ovalid) begin
        if (pulses == 0) begin
          check("busy_first_cycle", LW'(c), LW'(10));
          check("busy_first_res", LW'(s_res), LW'(3));
        end else begin
          check("busy_second_cycle", LW'(c), LW'(21));
          check("busy_second_res", LW'(s_res), LW'(1));
        end
        pulses++;
      end
    end
    check("busy_pulse_count", LW'(pulses), LW'(2));

    // reset four cycles into a run
    start_small(16'd13, 16'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", LW'(s_ready), LW'(1));
    check("midrst_valid", LW'(s_ovalid), LW'(0));
    check("midrst_res", LW'(s_res), LW'(0));
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_ovalid) pulses++;
    end
    check("midrst_no_pulse", LW'(pulses), LW'(0));
    op_small("post_rst", 16'd13, 16'd1, 16'd3, 1'b0, 1'b1);

    // full-width random vectors, first two pin T at 0 and 2N-1
    for (int i = 0; i < NVEC; i++) begin
      n = rand_wide() >> $urandom_range(1, 258);
      n[0] = 1'b1;
      if (i == 0) t = '0;
      else if (i == 1) t = (n << 1) - LW'(1);
      else t = rand_wide() % (n << 1);
      op_large(n, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
